// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle RISC-V style control FSM with a memory handshake timeout and a sticky trap
module multicycle_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        ir_we,
  output logic        pc_we,
  output logic        reg_we,
  output logic [1:0]  imm_sel,
  output logic [19:0] imm_field,
  output logic        alu_src_imm,
  output logic        trap,
  output logic [2:0]  state
);
  typedef enum logic [2:0] {FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4, TRAP = 3'd5} state_t;
  typedef enum logic [2:0] {C_R, C_I, C_LD, C_ST, C_BR, C_U, C_J, C_BAD} cls_t;
  localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);
  state_t      state_q, state_d;
  cls_t        cls_q, cls_d, cls_in;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  imm_sel_q, imm_sel_d, sel_in;
  logic [19:0] imm_field_q, imm_field_d, fld_in;
  logic        waiting, timed_out, hs;
  always_comb begin
    cls_in = C_BAD;
    sel_in = 2'd0;
    fld_in = 20'd0;
    case (instr[6:0])
      7'b0000011: begin cls_in = C_LD; fld_in = {8'd0, instr[31:20]}; end
      7'b0010011, 7'b1100111: begin cls_in = C_I; fld_in = {8'd0, instr[31:20]}; end
      7'b0100011: begin cls_in = C_ST; fld_in = {8'd0, instr[31:25], instr[11:7]}; end
      7'b1100011: begin cls_in = C_BR; sel_in = 2'd1; fld_in = {8'd0, instr[31], instr[7], instr[30:25], instr[11:8]}; end
      7'b0110111, 7'b0010111: begin cls_in = C_U; sel_in = 2'd2; fld_in = instr[31:12]; end
      7'b1101111: begin cls_in = C_J; sel_in = 2'd3; fld_in = {instr[31], instr[19:12], instr[20], instr[30:21]}; end
      7'b0110011: cls_in = C_R;
      default: cls_in = C_BAD;
    endcase
  end
  // a timeout wins over a simultaneous mem_ready
  assign waiting   = state_q == FETCH || state_q == MEM;
  assign timed_out = waiting && cnt_q == TIMEOUT;
  assign hs        = waiting && mem_ready && !timed_out;
  always_comb begin
    state_d     = state_q;
    cls_d       = cls_q;
    imm_sel_d   = imm_sel_q;
    imm_field_d = imm_field_q;
    case (state_q)
      FETCH:   state_d = timed_out ? TRAP : hs ? DECODE : FETCH;
      DECODE:  state_d = cls_q == C_BAD ? TRAP : EXEC;
      EXEC:    state_d = (cls_q == C_LD || cls_q == C_ST) ? MEM : cls_q == C_BR ? FETCH : WB;
      MEM:     state_d = timed_out ? TRAP : !hs ? MEM : cls_q == C_ST ? FETCH : WB;
      WB:      state_d = FETCH;
      default: state_d = TRAP;
    endcase
    if (state_q == FETCH && hs) begin
      cls_d       = cls_in;
      imm_sel_d   = sel_in;
      imm_field_d = fld_in;
    end
    cnt_d = state_d != state_q ? 8'd0 : (waiting && !mem_ready) ? cnt_q + 8'd1 : cnt_q;
    if (reset) begin
      state_d     = FETCH;
      cls_d       = C_R;
      imm_sel_d   = 2'd0;
      imm_field_d = 20'd0;
      cnt_d       = 8'd0;
    end
  end
  always_ff @(posedge clk) begin
    state_q     <= state_d;
    cls_q       <= cls_d;
    cnt_q       <= cnt_d;
    imm_sel_q   <= imm_sel_d;
    imm_field_q <= imm_field_d;
  end
  assign mem_req     = waiting;
  assign mem_we      = state_q == MEM && cls_q == C_ST;
  assign ir_we       = state_q == FETCH && hs;
  assign pc_we       = (state_q == EXEC && cls_q == C_BR) || (state_q == MEM && hs && cls_q == C_ST) || state_q == WB;
  assign reg_we      = state_q == WB;
  assign imm_sel     = imm_sel_q;
  assign imm_field   = imm_field_q;
  assign alu_src_imm = cls_q != C_R;
  assign trap        = state_q == TRAP;
  assign state       = state_q;
endmodule
